// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier
//   Multi-cycle shift-and-add multiplier with per-operation unsigned or
//   two's-complement signed mode. Each operation processes one multiplier
//   bit per clock. Latency is fixed at WIDTH+1 cycles from the start edge
//   to the done edge.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        operation request, accepted in IDLE or in the done cycle
//   signed_mode  0 = unsigned, 1 = two's-complement signed (captured with start)
//   a            multiplicand (captured with start)
//   b            multiplier   (captured with start)
//   busy         high while an operation is in progress
//   done         one-cycle pulse, product valid
//   product      2*WIDTH-bit result, held until the next completion
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH:0]   acc;
  logic               neg;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     upper_sum;

  // Magnitude of an operand as a WIDTH-bit unsigned value. The most-negative
  // signed value maps to 2^(WIDTH-1), which is representable unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sm);
    logic signed [WIDTH-1:0] xs;
    xs = x;
    if (sm && xs < 0)
      return ~x + WIDTH'(1);
    else
      return x;
  endfunction

  // Re-apply the result sign over the full product width.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                    input logic               n);
    if (n)
      return ~m + (2*WIDTH)'(1);
    else
      return m;
  endfunction

  // Upper half plus optional multiplicand; the extra bit keeps the carry.
  always_comb begin
    upper_sum = '0;
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= magnitude(a, signed_mode);
            mplier <= magnitude(b, signed_mode);
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (cnt == CNT_W'(WIDTH)) begin
            // All bits consumed: the extra edge registers the signed result.
            // A zero magnitude negates to zero, so no negative zero appears.
            product <= apply_sign(acc[2*WIDTH-1:0], neg);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end else begin
            acc    <= {upper_sum, acc[WIDTH-1:0]} >> 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  seq_shift_add_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one WIDTH=8 operation; returns edges from start to done (-1 on timeout)
  // and the number of cycles where busy disagreed with the expected handshake.
  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     output int lat, output int busy_bad);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = -1;
    busy_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done8) begin
        lat = n;
        if (busy8) busy_bad++;
        break;
      end
      if (!busy8) busy_bad++;
    end
  endtask

  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                     output int lat);
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    step();
    start4 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (done4) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, bb, nd, de, ai, bi, ref4;

    vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[1]  = '{1'b0, 8'h00, 8'h00, 16'h0000};
    vecs[2]  = '{1'b0, 8'h0F, 8'h11, 16'h00FF};
    vecs[3]  = '{1'b0, 8'hC8, 8'h03, 16'h0258};
    vecs[4]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[5]  = '{1'b0, 8'hFD, 8'h05, 16'h04F1};
    vecs[6]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[7]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[8]  = '{1'b1, 8'h80, 8'h01, 16'hFF80};
    vecs[9]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[10] = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[11] = '{1'b1, 8'h00, 8'hC8, 16'h0000};
    vecs[12] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};

    rst = 1'b1;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset product", 32'(product8), 32'd0);
    chk("reset product w4", 32'(product4), 32'd0);
    step();

    // Directed vector table, WIDTH=8
    for (int i = 0; i < 13; i++) begin
      op8(vecs[i].sm, vecs[i].a, vecs[i].b, lat, bb);
      chk($sformatf("vec%0d product", i), 32'(product8), 32'(vecs[i].exp));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd9);
      chk($sformatf("vec%0d busy", i), 32'(bb), 32'd0);
      step();
      chk($sformatf("vec%0d done low", i), 32'(done8), 32'd0);
      chk($sformatf("vec%0d product hold", i), 32'(product8), 32'(vecs[i].exp));
    end

    // Start while busy is ignored, input changes after capture have no effect
    sm8 = 1'b0; a8 = 8'd3; b8 = 8'd4; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    step();
    start8 = 1'b0; a8 = 8'd5; b8 = 8'd5;
    nd = 0; de = -1;
    for (int n = 5; n <= 30; n++) begin
      step();
      if (done8) begin
        nd++;
        if (de < 0) begin
          de = n;
          chk("ignore product", 32'(product8), 32'd12);
        end
      end
    end
    chk("ignore done edge", 32'(de), 32'd9);
    chk("ignore done count", 32'(nd), 32'd1);

    // Back-to-back: second start accepted in the done cycle
    sm8 = 1'b0; a8 = 8'd2; b8 = 8'd3; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int n = 1; n <= 9; n++) step();
    chk("b2b first done", 32'(done8), 32'd1);
    chk("b2b first product", 32'(product8), 32'd6);
    chk("b2b first busy", 32'(busy8), 32'd0);
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd6;
    step();
    start8 = 1'b0;
    chk("b2b restart busy", 32'(busy8), 32'd1);
    chk("b2b restart done", 32'(done8), 32'd0);
    for (int n = 11; n <= 19; n++) step();
    chk("b2b second done", 32'(done8), 32'd1);
    chk("b2b second product", 32'(product8), 32'd42);
    chk("b2b second busy", 32'(busy8), 32'd0);
    step();

    // Reset mid-operation aborts without a done pulse
    sm8 = 1'b0; a8 = 8'd100; b8 = 8'd100; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1; start8 = 1'b1;
    step();
    rst = 1'b0; start8 = 1'b0;
    chk("abort busy", 32'(busy8), 32'd0);
    chk("abort done", 32'(done8), 32'd0);
    chk("abort product", 32'(product8), 32'd0);
    nd = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (done8 || busy8) nd++;
    end
    chk("abort no activity", 32'(nd), 32'd0);
    op8(1'b1, 8'd0, 8'd200, lat, bb);
    chk("after abort product", 32'(product8), 32'd0);
    chk("after abort latency", 32'(lat), 32'd9);
    step();

    // WIDTH=4 exhaustive sweep in both modes
    for (int m = 0; m < 2; m++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          op4(m[0], x[3:0], y[3:0], lat);
          ai = (m == 1 && x >= 8) ? x - 16 : x;
          bi = (m == 1 && y >= 8) ? y - 16 : y;
          ref4 = (ai * bi) & 8'hFF;
          chk($sformatf("w4 m%0d %0d*%0d product", m, x, y), 32'(product4), 32'(ref4));
          chk($sformatf("w4 m%0d %0d*%0d latency", m, x, y), 32'(lat), 32'd5);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
Name: seq_shift_add_multiplier

Overview:
- Parametrised, multi-cycle shift-and-add multiplier. It is the sequential successor to the fixed 4x4 combinational array multiplier.
- Operand width is set by a parameter. Per-operation mode selects unsigned or two's-complement signed multiplication.
- A start/busy/done handshake makes it usable by datapath controllers that cannot afford a WIDTH x WIDTH combinational array.
- Produces one product bit-iteration per clock.

Parameters:
- WIDTH, 8, operand width in bits (minimum 2); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when idle or in DONE
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; captured with start
- a  input  WIDTH  multiplicand; captured with start
- b  input  WIDTH  multiplier; captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: product is valid
- product  output  2*WIDTH  result; holds the last value until the next completion

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: busy=0, done=0, product=0, state=IDLE, internal accumulator, operand and counter registers all 0.
- FSM states: IDLE, CALC, DONE.
- IDLE: if start=1 at edge k:
  - capture a, b, signed_mode;
  - go to CALC; busy=1 from edge k; counter=0.
  - Otherwise stay.
- Operand capture:
  - unsigned mode: magnitudes are a and b as-is.
  - signed mode: magnitude = absolute value of each operand, computed as WIDTH-bit unsigned. The most-negative value -2^(WIDTH-1) maps to magnitude 2^(WIDTH-1) with no overflow. Result sign = a[WIDTH-1] XOR b[WIDTH-1].
- CALC: one iteration per edge, edges k+1 .. k+WIDTH.
  - Examine the multiplier LSB.
  - If 1, add the multiplicand into the upper half of the 2*WIDTH+1-bit accumulator (the carry bit is kept).
  - Shift the accumulator right by 1.
  - After WIDTH iterations (counter = WIDTH-1 at the edge), go to DONE.
- DONE entry (edge k+WIDTH+1):
  - product <= accumulator, two's-complement negated over 2*WIDTH bits if signed mode and the result sign is 1;
  - done=1 and busy=0 for exactly this one cycle.
- Fixed latency: start sampled at edge k -> done high and product valid after edge k+WIDTH+1. Latency = WIDTH+1 cycles, independent of operand values (no early termination).
- DONE -> IDLE at the next edge. If start=1 in the DONE cycle, it is accepted at once: go directly to CALC, busy=1, done=0 (back-to-back ops every WIDTH+1 cycles).
- start while busy (CALC): ignored; the operation in progress and the captured operands are unaffected.
- Changes to a, b or signed_mode after capture have no effect.
- Arithmetic: the result is exact for all inputs; no overflow is possible in 2*WIDTH bits.
  - Unsigned max: (2^WIDTH-1)^2.
  - Signed extreme: (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), positive and fits.
  - A zero operand in signed mode gives +0, never negative zero.
- product changes only on DONE entry or reset. It is stable while busy and between operations.
- Reset mid-operation (rst=1 in any state): all registers and outputs return to reset values at that edge. No done pulse is produced for the aborted op. start is ignored in the cycle rst=1.

Test Plan:
- WIDTH=8, unsigned: a=255, b=255, start at edge 0.
  -> busy high edges 0..8; done=1 exactly after edge 9; product=16'hFE01; done low after edge 10.
- WIDTH=8, signed_mode=1:
  - a=8'hFD (-3), b=8'h05 -> product=16'hFFF1 (-15).
  - a=8'h80, b=8'h80 -> product=16'h4000.
  - a=8'h80, b=8'h01 -> product=16'hFF80.
- Start ignored while busy: start a=3,b=4; at edge 4 pulse start with a=9,b=9 and change the a/b inputs.
  -> single done after edge 9 with product=12; no second done follows.
- Back-to-back: start a=2,b=3 at edge 0; hold start=1 with a=7,b=6 in the DONE cycle (after edge 9).
  -> product=6 at edge 9; done again after edge 19 with product=42; busy low only during the done cycles.
- Reset mid-op:
  - Start a=100,b=100; assert rst at edge 5 for one cycle -> busy=0, done=0, product=0; no done pulse is ever emitted.
  - Then start a=0,b=200 signed_mode=1 -> product=0.
- Parametrisation: WIDTH=4 exhaustive sweep of all 256 operand pairs in both modes vs a reference model.
  -> every product correct; latency exactly 5 cycles.
